axis_fp16_pattern_src_128: RTL

//  AXI4-Stream master that generates frames of 128b beats (8 x FP16 lanes, lane k = tdata[16k+:16]).

---
 rtl/axis_fp16_pattern_src_128.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axis_fp16_pattern_src_128.sv
// ---------------------------------------------------------------------------
// axis_fp16_pattern_src_128
//
// AXI4-Stream master that emits one frame of 128-bit beats per software
// start. Each beat holds eight FP16 lanes (lane k = m_tdata[16k +: 16]).
// Three payload generators are available:
//   CONST : every lane carries the fill value
//   COUNT : lane k of beat b carries {b[12:0], k[2:0]}
//   LFSR  : per-lane 16-bit Galois LFSR (taps 16'hB400). The seed is
//           fill ^ {4{1'b0,k}}. A zero seed becomes DFLT_SEED.
// Mode 3 is reserved and behaves like CONST.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   start                1-cycle request, only honoured while idle
//   num_beats            frame length, latched on an accepted start
//   mode, fill           generator select and fill/seed base, latched on start
//   abort                level; marks the next not-yet-presented beat as last
//   m_tdata/m_tvalid/
//   m_tready/m_tlast     AXI4-Stream master channel
//   busy                 high while a frame is in progress
//   done                 1-cycle pulse after the final handshake, or after
//                        a start with num_beats == 0
//   beat_count           beats handshaked in the current/last frame
// ---------------------------------------------------------------------------
module axis_fp16_pattern_src_128 #(
  parameter int          LEN_W     = 16,
  parameter logic [15:0] DFLT_SEED = 16'hACE1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [LEN_W-1:0] num_beats,
  input  logic [1:0]       mode,
  input  logic [15:0]      fill,
  input  logic             abort,
  output logic [127:0]     m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] beat_count
);

  localparam logic [1:0]       MODE_COUNT = 2'd1;
  localparam logic [1:0]       MODE_LFSR  = 2'd2;
  localparam logic [15:0]      LFSR_TAPS  = 16'hB400;
  localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state;
  state_t state_next;

  // Frame configuration captured on an accepted start
  logic [LEN_W-1:0] cfg_num;
  logic [1:0]       cfg_mode;
  logic [15:0]      cfg_fill;

  // Index of the beat currently presented on m_tdata
  logic [LEN_W-1:0] beat_idx;

  // Abort seen during this frame; applies to the next beat presented
  logic             abort_req;

  // LFSR lane values for the beat currently presented
  logic [127:0]     lfsr_lanes;

  // Control strobes from the FSM
  logic             handshake;
  logic             load_frame;
  logic             load_empty;
  logic             advance;
  logic             finish;

  // Datapath values computed ahead of the register update
  logic [127:0]     seeds_in;
  logic [127:0]     first_beat;
  logic [127:0]     lanes_stepped;
  logic [LEN_W-1:0] idx_next;
  logic [127:0]     next_beat;
  logic             next_last;

  // One step of the right-shifting Galois LFSR
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) begin
      r = r ^ LFSR_TAPS;
    end
    return r;
  endfunction

  // Per-lane seeds for a given fill; an all-zero seed would lock the LFSR
  function automatic logic [127:0] lane_seeds(input logic [15:0] base);
    logic [127:0] r;
    logic [15:0]  s;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      s = base ^ {4{1'b0, 3'(k)}};
      if (s == 16'h0000) begin
        s = DFLT_SEED;
      end
      r[16*k +: 16] = s;
    end
    return r;
  endfunction

  // Assemble a full beat from the generator mode, beat index and LFSR lanes
  function automatic logic [127:0] make_beat(
    input logic [1:0]   md,
    input logic [15:0]  fl,
    input logic [12:0]  b,
    input logic [127:0] lanes
  );
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      case (md)
        MODE_COUNT: r[16*k +: 16] = {b, 3'(k)};
        MODE_LFSR:  r[16*k +: 16] = lanes[16*k +: 16];
        default:    r[16*k +: 16] = fl;
      endcase
    end
    return r;
  endfunction

  assign m_tvalid  = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign handshake = m_tvalid & m_tready;

  // Next-state logic and control strobes. A zero-length start never
  // leaves IDLE; a handshake on the last beat returns to IDLE.
  always_comb begin
    state_next = state;
    load_frame = 1'b0;
    load_empty = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_beats == '0) begin
            load_empty = 1'b1;
          end else begin
            load_frame = 1'b1;
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (handshake) begin
          if (m_tlast) begin
            finish     = 1'b1;
            state_next = S_IDLE;
          end else begin
            advance    = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Beat generation: the first beat comes straight from the start inputs,
  // and later beats come from the latched configuration. An abort seen in
  // the current cycle, or earlier in the frame, marks the upcoming beat as
  // last. The beat already on the bus is never changed.
  always_comb begin
    lanes_stepped = '0;
    for (int k = 0; k < 8; k++) begin
      lanes_stepped[16*k +: 16] = lfsr_step(lfsr_lanes[16*k +: 16]);
    end
    seeds_in   = lane_seeds(fill);
    first_beat = make_beat(mode, fill, 13'd0, seeds_in);
    idx_next   = beat_idx + ONE;
    next_beat  = make_beat(cfg_mode, cfg_fill, 13'(idx_next), lanes_stepped);
    next_last  = (idx_next == (cfg_num - ONE)) | abort_req | abort;
  end

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and status registers. Later assignments deliberately
  // override earlier ones, so "finish" clears the pending abort.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_num    <= '0;
      cfg_mode   <= '0;
      cfg_fill   <= '0;
      beat_idx   <= '0;
      beat_count <= '0;
      abort_req  <= 1'b0;
      lfsr_lanes <= '0;
      m_tdata    <= '0;
      m_tlast    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= load_empty | finish;

      if (load_frame | load_empty) begin
        cfg_num    <= num_beats;
        cfg_mode   <= mode;
        cfg_fill   <= fill;
        beat_idx   <= '0;
        beat_count <= '0;
        abort_req  <= 1'b0;
      end

      if (load_frame) begin
        lfsr_lanes <= seeds_in;
        m_tdata    <= first_beat;
        m_tlast    <= (num_beats == ONE);
      end

      if ((state == S_RUN) && abort) begin
        abort_req <= 1'b1;
      end

      // Count never exceeds cfg_num, so it cannot wrap even at all-ones
      if (handshake) begin
        beat_count <= beat_count + ONE;
      end

      if (advance) begin
        beat_idx   <= idx_next;
        lfsr_lanes <= lanes_stepped;
        m_tdata    <= next_beat;
        m_tlast    <= next_last;
      end

      if (finish) begin
        m_tdata   <= '0;
        m_tlast   <= 1'b0;
        abort_req <= 1'b0;
      end
    end
  end

endmodule
